bam_dot_acc: RTL and testbench

BAM_DOT_ACC -- requirements
Module: bam_dot_acc

---
 rtl/bam_dot_acc_pkg.sv | 17 +
 rtl/BAM_8x8.sv | 32 +++
 rtl/bam_dot_acc.sv | 156 +++++++++++++++
 tb/tb_bam_dot_acc.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bam_dot_acc_pkg.sv
// bam_dot_acc_pkg
// Shared definitions for the approximate dot-product accumulator:
//   state_t           FSM state encoding (IDLE / ACCUM / HOLD)
//   ACC_W_DEFAULT     default accumulator / result width
//   CNT_W_DEFAULT     default beat-counter width
package bam_dot_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int ACC_W_DEFAULT = 32;
    localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/BAM_8x8.sv
// BAM_8x8
// Broken-array approximate unsigned multiplier. Every partial-product bit
// a[i]&b[j] whose column (i+j) lies below the vertical breaking level VBL
// is dropped; VBL = 0 gives an exact product.
// Ports:
//   a  in  WIDTH    operand A
//   b  in  WIDTH    operand B
//   p  out 2*WIDTH  approximate product
module BAM_8x8 #(
    parameter int WIDTH = 8,
    parameter int VBL   = 0
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);

    localparam int PW = 2 * WIDTH;

    // Sum only the partial-product bits that survive the vertical break.
    always_comb begin
        p = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                if ((i + j) >= VBL) begin
                    p = p + (PW'(a[i] & b[j]) << (i + j));
                end
            end
        end
    end

endmodule

// File: rtl/bam_dot_acc.sv
// bam_dot_acc
// Streaming dot-product accumulator built on the BAM_8x8 approximate
// multiplier. Beats are multiplied and registered in stage P, then added
// into a saturating accumulator in stage A. After the beat flagged last has
// been added the result is held until the consumer takes it.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand beat offered
//   in_ready   out  1      beat accepted when in_valid && in_ready
//   in_a       in   WIDTH  unsigned operand A
//   in_b       in   WIDTH  unsigned operand B
//   in_last    in   1      final beat of the dot product
//   out_valid  out  1      result available
//   out_ready  in   1      consumer takes the result
//   out_data   out  ACC_W  accumulated (saturated) sum
//   out_cnt    out  CNT_W  beats summed, modulo 2^CNT_W
//   out_sat    out  1      sum clamped at least once
import bam_dot_acc_pkg::*;

module bam_dot_acc #(
    parameter int WIDTH = 8,
    parameter int VBL   = 2,
    parameter int ACC_W = ACC_W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_sat
);

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] p_prod;
    logic               p_valid;
    logic               p_last;
    logic               run;
    logic               accept;
    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               sat;
    logic [ACC_W:0]     sum;

    BAM_8x8 #(
        .WIDTH (WIDTH),
        .VBL   (VBL)
    ) u_mult (
        .a (in_a),
        .b (in_b),
        .p (prod)
    );

    // p_last stays high from the capture of the last beat until HOLD is
    // entered, so it alone blocks new beats during the drain of the pipe.
    assign in_ready = run && (state != HOLD) && !p_last;
    assign accept   = in_valid && in_ready;

    // One extra carry bit detects overflow of the accumulator.
    assign sum = {1'b0, acc} + {1'b0, ACC_W'(p_prod)};

    // Holds in_ready low during reset and releases it on the first edge
    // after rst_n deasserts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Stage P: register product and last flag of every accepted beat.
    // p_last is dropped in the cycle after its product was added, which is
    // the same edge the FSM moves into HOLD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            p_prod  <= '0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                p_prod <= prod;
                p_last <= in_last;
            end else if (p_last && !p_valid) begin
                p_last <= 1'b0;
            end
        end
    end

    // Stage A plus control FSM. The accumulator adds the stage-P product
    // with clamping; once the last product is in, the totals are copied
    // into the registered outputs and held until the handshake, which
    // clears everything for the next dot product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (p_valid) begin
                        cnt <= cnt + CNT_W'(1);
                        if (sum[ACC_W]) begin
                            acc <= '1;
                            sat <= 1'b1;
                        end else begin
                            acc <= sum[ACC_W-1:0];
                        end
                    end else if (p_last) begin
                        state     <= HOLD;
                        out_valid <= 1'b1;
                        out_data  <= acc;
                        out_cnt   <= cnt;
                        out_sat   <= sat;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        cnt       <= '0;
                        sat       <= 1'b0;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_cnt   <= '0;
                        out_sat   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bam_dot_acc.sv
// tb_bam_dot_acc
// Three accumulator instances share one clock, reset and stimulus bus:
//   0: exact      (VBL=0, ACC_W=32)
//   1: saturating (VBL=0, ACC_W=16)
//   2: approx     (VBL=4, ACC_W=32)
// "sel" routes in_valid/out_ready to one instance and muxes its outputs.
module tb_bam_dot_acc;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  cnt;
        logic        sat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_last;
    logic        out_ready;
    int          sel;

    logic        ready0, ready1, ready2;
    logic        valid0, valid1, valid2;
    logic [31:0] data0, data2;
    logic [15:0] data1;
    logic [7:0]  cnt0, cnt1, cnt2;
    logic        sat0, sat1, sat2;

    logic        m_ready, m_valid, m_sat;
    logic [31:0] m_data;
    logic [7:0]  m_cnt;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          accept_edge = 0;
    int          last_edge   = 0;
    int          hs_edge     = 0;
    longint      model_acc = 0;
    logic [7:0]  model_cnt = '0;
    logic        model_sat = 1'b0;

    bam_dot_acc #(.WIDTH(8), .VBL(0), .ACC_W(32), .CNT_W(8)) u_exact (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid && sel == 0), .in_ready(ready0),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(valid0), .out_ready(out_ready && sel == 0),
        .out_data(data0), .out_cnt(cnt0), .out_sat(sat0)
    );

    bam_dot_acc #(.WIDTH(8), .VBL(0), .ACC_W(16), .CNT_W(8)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid && sel == 1), .in_ready(ready1),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(valid1), .out_ready(out_ready && sel == 1),
        .out_data(data1), .out_cnt(cnt1), .out_sat(sat1)
    );

    bam_dot_acc #(.WIDTH(8), .VBL(4), .ACC_W(32), .CNT_W(8)) u_approx (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid && sel == 2), .in_ready(ready2),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(valid2), .out_ready(out_ready && sel == 2),
        .out_data(data2), .out_cnt(cnt2), .out_sat(sat2)
    );

    // Route the selected instance onto the observed bus.
    always_comb begin
        m_ready = ready0;
        m_valid = valid0;
        m_data  = data0;
        m_cnt   = cnt0;
        m_sat   = sat0;
        if (sel == 1) begin
            m_ready = ready1;
            m_valid = valid1;
            m_data  = {16'h0000, data1};
            m_cnt   = cnt1;
            m_sat   = sat1;
        end else if (sel == 2) begin
            m_ready = ready2;
            m_valid = valid2;
            m_data  = data2;
            m_cnt   = cnt2;
            m_sat   = sat2;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Golden broken-array product built row by row: each row a<<j is masked
    // below column vbl before being added.
    function automatic longint approxMul(input int a, input int b, input int vbl);
        longint s;
        longint mask;
        s = 0;
        mask = ~((longint'(1) << vbl) - 1);
        for (int j = 0; j < 8; j++) begin
            if (((b >> j) & 1) != 0) begin
                s += (longint'(a) << j) & mask;
            end
        end
        return s;
    endfunction

    function automatic longint accMax();
        return (sel == 1) ? 64'd65535 : 64'd4294967295;
    endfunction

    task automatic clearModel();
        model_acc = 0;
        model_cnt = '0;
        model_sat = 1'b0;
    endtask

    // Offer one beat until it is accepted, then update the reference
    // accumulator and queue the expected result on the last beat.
    task automatic applyStimulus(input int a, input int b, input bit last);
        int   waited;
        bit   got;
        exp_t e;
        in_valid = 1'b1;
        in_a     = 8'(a);
        in_b     = 8'(b);
        in_last  = last;
        waited   = 0;
        got      = 0;
        while (!got && waited < 200) begin
            @(negedge clk);
            if (m_ready) begin
                got = 1;
                accept_edge = cyc + 1;
            end else begin
                waited++;
            end
        end
        if (!got) begin
            checkOutput("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = 8'hA5;
        in_b     = 8'h5A;
        model_acc += approxMul(a, b, (sel == 2) ? 4 : 0);
        if (model_acc > accMax()) begin
            model_acc = accMax();
            model_sat = 1'b1;
        end
        model_cnt = model_cnt + 8'd1;
        if (last) begin
            e.data = 32'(model_acc);
            e.cnt  = model_cnt;
            e.sat  = model_sat;
            sb.push_back(e);
            clearModel();
            last_edge = accept_edge;
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 64'(sb.size()), 0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: latency of each result and scoreboard comparison on
    // every handshake.
    initial begin : monitor
        exp_t e;
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (m_valid && !prev_valid) begin
                checkOutput("latency", 64'(cyc - last_edge), 2);
            end
            if (m_valid && out_ready) begin
                hs_edge = cyc + 1;
                checkOutput("result_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checkOutput("out_data", m_data, e.data);
                    checkOutput("out_cnt", m_cnt, e.cnt);
                    checkOutput("out_sat", m_sat, e.sat);
                end
            end
            prev_valid = m_valid;
        end
    end

    initial begin
        int remaining;
        int len;
        logic [31:0] held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        sel       = 0;

        // Reset values and in_ready release.
        #3;
        checkOutput("rst_out_valid", m_valid, 0);
        checkOutput("rst_out_data", m_data, 0);
        checkOutput("rst_out_cnt", m_cnt, 0);
        checkOutput("rst_out_sat", m_sat, 0);
        checkOutput("rst_in_ready", m_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_before_edge", m_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("ready_after_edge", m_ready, 1);

        // Exact mode: 12 + 30 + 56 = 98.
        $display("[TB] exact dot product");
        applyStimulus(3, 4, 0);
        applyStimulus(5, 6, 0);
        applyStimulus(7, 8, 1);
        waitDrain();

        // Single-beat dot product.
        applyStimulus(200, 3, 1);
        waitDrain();

        // Backpressure: hold the result for five cycles, then one ready pulse.
        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(1, 2, 0);
        applyStimulus(3, 4, 1);
        begin
            int n;
            n = 0;
            while (!m_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        checkOutput("bp_valid", m_valid, 1);
        held = m_data;
        checkOutput("bp_data", held, 14);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_stable", m_data, held);
            checkOutput("bp_in_ready", m_ready, 0);
            checkOutput("bp_still_valid", m_valid, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checkOutput("bp_ready_after", m_ready, 1);
        checkOutput("bp_valid_after", m_valid, 0);
        checkOutput("idle_data_zero", m_data, 0);
        out_ready = 1'b1;
        waitDrain();

        // Back-to-back: the next beat waits until the cycle after the handshake.
        $display("[TB] back-to-back");
        applyStimulus(9, 10, 0);
        applyStimulus(11, 12, 1);
        applyStimulus(13, 14, 0);
        checkOutput("b2b_gap", 64'(accept_edge - hs_edge), 1);
        applyStimulus(15, 16, 1);
        waitDrain();

        // Counter wraps modulo 256 while data keeps counting.
        $display("[TB] count wrap");
        for (int i = 0; i < 258; i++) begin
            applyStimulus(1, 1, i == 257);
        end
        waitDrain();

        // Saturation on the 16-bit accumulator, then a clean result.
        $display("[TB] saturation");
        sel = 1;
        applyStimulus(255, 255, 0);
        applyStimulus(255, 255, 1);
        applyStimulus(1, 1, 1);
        waitDrain();

        // Reset in the middle of a dot product discards the partial sum.
        $display("[TB] reset mid-operation");
        sel = 0;
        applyStimulus(10, 10, 0);
        applyStimulus(20, 20, 0);
        #2;
        rst_n = 1'b0;
        clearModel();
        #1;
        checkOutput("midrst_valid", m_valid, 0);
        checkOutput("midrst_data", m_data, 0);
        checkOutput("midrst_cnt", m_cnt, 0);
        checkOutput("midrst_ready", m_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_ready_back", m_ready, 1);
        applyStimulus(2, 2, 1);
        waitDrain();

        // Approximate mode: single-beat products, then random dot products.
        $display("[TB] approximate mode");
        sel = 2;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1);
        end
        remaining = 800;
        while (remaining > 0) begin
            len = int'($urandom_range(1, 16));
            if (len > remaining) len = remaining;
            for (int k = 0; k < len; k++) begin
                applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                              k == len - 1);
            end
            remaining -= len;
        end
        waitDrain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
